// File: rtl/maxnet_controller_if.sv
// Bundles the MaxNet controller's system handshake and datapath control lines.
// master = controller side, slave = system/datapath side.
interface maxnet_controller_if #(
   parameter int ITER_W = 8
);
   // Handshake: start is a level request taken only while idle (no queuing);
   // busy covers the whole run and done pulses for one cycle as it ends.
   logic              start;
   logic              found;
   logic              mainRegWrite;
   logic              actWrite;
   logic              multWrite;
   logic              addWrite;
   logic              s1;
   logic              s2;
   logic              s3;
   logic              s4;
   logic              busy;
   logic              done;
   logic              timeout;
   logic [ITER_W-1:0] iter_count;

   modport master (
      input  start, found,
      output mainRegWrite, actWrite, multWrite, addWrite,
      output s1, s2, s3, s4, busy, done, timeout, iter_count
   );

   modport slave (
      output start, found,
      input  mainRegWrite, actWrite, multWrite, addWrite,
      input  s1, s2, s3, s4, busy, done, timeout, iter_count
   );
endinterface

// File: rtl/maxnet_controller.sv
// Sequencing FSM for the MaxNet winner-take-all datapath: load, seed, then
// iterate multiply/accumulate/feedback until one activation survives or the limit hits.
module maxnet_controller #(
   parameter int MAX_ITER    = 64,
   parameter int ITER_W      = 8,
   parameter int MULT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   maxnet_controller_if.master  bus,
   output logic [2:0]           dbg_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      INIT  = 3'd2,
      MULT  = 3'd3,
      ADD   = 3'd4,
      CHECK = 3'd5,
      FEED  = 3'd6,
      DONE  = 3'd7
   } state_t;

   localparam int MC_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
   localparam logic [MC_W-1:0]   MC_LAST  = MC_W'(MULT_CYCLES - 1);
   localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

   state_t            state;
   state_t            state_next;
   logic [MC_W-1:0]   mult_cnt;
   logic [ITER_W-1:0] iter_q;
   logic              timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mult_cnt  <= '0;
         iter_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state <= state_next;
         if (state == MULT && state_next == MULT) begin
            mult_cnt <= mult_cnt + 1'b1;
         end else begin
            mult_cnt <= '0;
         end
         if (state == IDLE && bus.start) begin
            iter_q    <= '0;
            timeout_q <= 1'b0;
         end
         if (state == ADD) begin
            iter_q <= iter_q + 1'b1;
         end
         // found wins over the limit, so timeout is only flagged when found is low
         if (state == CHECK && !bus.found && iter_q == ITER_MAX) begin
            timeout_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (bus.start) state_next = LOAD;
         LOAD:  state_next = INIT;
         INIT:  state_next = MULT;
         MULT:  if (mult_cnt == MC_LAST) state_next = ADD;
         ADD:   state_next = CHECK;
         CHECK: begin
            if (bus.found || iter_q == ITER_MAX) state_next = DONE;
            else                                 state_next = FEED;
         end
         FEED:  state_next = MULT;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.mainRegWrite = 1'b0;
      bus.actWrite     = 1'b0;
      bus.multWrite    = 1'b0;
      bus.addWrite     = 1'b0;
      bus.s1           = 1'b0;
      bus.s2           = 1'b0;
      bus.s3           = 1'b0;
      bus.s4           = 1'b0;
      bus.done         = 1'b0;
      bus.busy         = (state != IDLE);
      case (state)
         LOAD: bus.mainRegWrite = 1'b1;
         INIT: bus.actWrite     = 1'b1;
         MULT: bus.multWrite    = 1'b1;
         ADD:  bus.addWrite     = 1'b1;
         FEED: begin
            bus.actWrite = 1'b1;
            bus.s1       = 1'b1;
            bus.s2       = 1'b1;
            bus.s3       = 1'b1;
            bus.s4       = 1'b1;
         end
         DONE: bus.done = 1'b1;
         default: ;
      endcase
   end

   assign bus.timeout    = timeout_q;
   assign bus.iter_count = iter_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_maxnet_controller.sv
// Bench for maxnet_controller: two instances with different iteration limits and
// multiply lengths, checked every cycle against a run-timeline model.
module tb_maxnet_controller;

   localparam int W    = 8;
   localparam int MI_A = 4;
   localparam int MC_A = 1;
   localparam int MI_B = 3;
   localparam int MC_B = 3;

   typedef struct packed {
      logic         mrw;
      logic         aw;
      logic         mw;
      logic         adw;
      logic [3:0]   s;
      logic         busy;
      logic         done;
      logic         to;
      logic [W-1:0] iter;
   } obs_t;

   typedef struct packed {
      int run;
      int k;
      int iter;
      int to;
      int ende;
   } mdl_t;

   logic clk = 1'b0;
   logic rst;
   logic st [2];
   logic fd [2];
   logic [2:0] dbg_a;
   logic [2:0] dbg_b;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   chk_en   = 1'b0;
   mdl_t m [2];
   obs_t act [2];

   always #5 clk = ~clk;

   maxnet_controller_if #(.ITER_W(W)) ifa ();
   maxnet_controller_if #(.ITER_W(W)) ifb ();

   maxnet_controller #(.MAX_ITER(MI_A), .ITER_W(W), .MULT_CYCLES(MC_A)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa.master), .dbg_state(dbg_a));
   maxnet_controller #(.MAX_ITER(MI_B), .ITER_W(W), .MULT_CYCLES(MC_B)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb.master), .dbg_state(dbg_b));

   assign ifa.start = st[0];
   assign ifa.found = fd[0];
   assign ifb.start = st[1];
   assign ifb.found = fd[1];
   assign act[0] = {ifa.mainRegWrite, ifa.actWrite, ifa.multWrite, ifa.addWrite,
                    ifa.s4, ifa.s3, ifa.s2, ifa.s1, ifa.busy, ifa.done, ifa.timeout,
                    ifa.iter_count};
   assign act[1] = {ifb.mainRegWrite, ifb.actWrite, ifb.multWrite, ifb.addWrite,
                    ifb.s4, ifb.s3, ifb.s2, ifb.s1, ifb.busy, ifb.done, ifb.timeout,
                    ifb.iter_count};

   function automatic int mc_of(input int i);
      return (i == 0) ? MC_A : MC_B;
   endfunction

   function automatic int mi_of(input int i);
      return (i == 0) ? MI_A : MI_B;
   endfunction

   // Position k cycles after the accepted start: 1 load, 2 seed, then blocks of
   // mc multiply cycles, one add, one check, one feedback-or-finish slot.
   function automatic int phase(input int k, input int mc);
      int r;
      if (k == 1) return 1;
      if (k == 2) return 2;
      r = (k - 3) % (mc + 3);
      if (r < mc)      return 3;
      if (r == mc)     return 4;
      if (r == mc + 1) return 5;
      return 6;
   endfunction

   function automatic mdl_t step(input mdl_t s, input logic r, input logic sv,
                                 input logic fv, input int mc, input int mi);
      mdl_t n;
      int   p;
      n = s;
      if (r) begin
         n = '0;
      end else if (s.run == 0) begin
         if (sv) begin
            n.run = 1; n.k = 1; n.iter = 0; n.to = 0; n.ende = 0;
         end
      end else begin
         p = phase(s.k, mc);
         if (p == 4) n.iter = s.iter + 1;
         if (p == 5) begin
            if (fv) n.ende = 1;
            else if (s.iter == mi) begin n.ende = 1; n.to = 1; end
         end
         if (p == 6 && s.ende != 0) begin
            n.run = 0; n.ende = 0;
         end else begin
            n.k = s.k + 1;
         end
      end
      return n;
   endfunction

   function automatic obs_t exp_of(input mdl_t s, input int mc);
      obs_t e;
      e      = '0;
      e.iter = W'(s.iter);
      e.to   = (s.to != 0);
      if (s.run != 0) begin
         e.busy = 1'b1;
         case (phase(s.k, mc))
            1: e.mrw = 1'b1;
            2: e.aw  = 1'b1;
            3: e.mw  = 1'b1;
            4: e.adw = 1'b1;
            6: begin
               if (s.ende != 0) e.done = 1'b1;
               else begin e.aw = 1'b1; e.s = 4'hF; end
            end
            default: ;
         endcase
      end
      return e;
   endfunction

   task automatic check(input string name, input int a, input int e);
      checks++;
      if (a != e) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, a, e);
      end
   endtask

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      m[0] <= step(m[0], rst, st[0], fd[0], MC_A, MI_A);
      m[1] <= step(m[1], rst, st[1], fd[1], MC_B, MI_B);
   end

   always @(negedge clk) begin : compare
      obs_t e;
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            e = exp_of(m[i], mc_of(i));
            checks++;
            if (act[i] !== e) begin
               failures++;
               $display("FAIL cycle_%0d inst%0d outputs actual=%h required=%h",
                        cyc, i, act[i], e);
            end
         end
      end
   end

   // One run on instance idx: found rises once the completed-iteration count hits tgt.
   task automatic go(input int idx, input int tgt, input int pulse_c, input int hold_from,
                     output int off, output int mw, output int feeds);
      off = -1; mw = 0; feeds = 0;
      @(negedge clk);
      st[idx] = 1'b1;
      fd[idx] = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (act[idx].mw) mw++;
         if (act[idx].s != 4'h0) feeds++;
         if (act[idx].done) begin
            off = c;
            break;
         end
         st[idx] = (c == pulse_c) || (hold_from > 0 && c >= hold_from);
         fd[idx] = (m[idx].iter == tgt);
      end
      if (off < 0) begin
         checks++;
         failures++;
         $display("FAIL inst%0d_done_timeout actual=none required=done_within_200", idx);
      end
   endtask

   initial begin
      int off, mw, feeds, seen;
      rst = 1'b1;
      st[0] = 1'b0; st[1] = 1'b0;
      fd[0] = 1'b0; fd[1] = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", int'(ifa.busy), 0);
      check("rst_iter", int'(ifa.iter_count), 0);
      check("rst_outputs", int'(act[0]), 0);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      go(0, 1, 0, 0, off, mw, feeds);
      check("n1_done_cycle", off, 6);
      check("n1_iter", int'(act[0].iter), 1);
      check("n1_timeout", int'(act[0].to), 0);
      check("n1_feeds", feeds, 0);
      check("n1_mult_cycles", mw, 1);

      go(0, 3, 0, 0, off, mw, feeds);
      check("n3_done_cycle", off, 14);
      check("n3_iter", int'(act[0].iter), 3);
      check("n3_feeds", feeds, 2);

      go(0, 99, 0, 0, off, mw, feeds);
      check("limit_done_cycle", off, 18);
      check("limit_timeout", int'(act[0].to), 1);
      check("limit_iter", int'(act[0].iter), 4);
      @(negedge clk);
      check("limit_timeout_held", int'(act[0].to), 1);

      go(0, 4, 0, 0, off, mw, feeds);
      check("last_found_done_cycle", off, 18);
      check("last_found_timeout", int'(act[0].to), 0);
      check("last_found_iter", int'(act[0].iter), 4);

      go(1, 1, 0, 0, off, mw, feeds);
      check("mc3_done_cycle", off, 8);
      check("mc3_mult_cycles", mw, 3);

      go(0, 1, 3, 5, off, mw, feeds);
      check("held_first_done_cycle", off, 6);
      @(negedge clk);
      check("held_idle_busy", int'(act[0].busy), 0);
      @(negedge clk);
      check("held_relaunch_load", int'(act[0].mrw), 1);
      check("held_relaunch_iter", int'(act[0].iter), 0);
      st[0] = 1'b0;
      seen = 0;
      for (int c = 0; c < 40 && seen == 0; c++) begin
         fd[0] = (m[0].iter == 2);
         @(negedge clk);
         if (act[0].done) seen = 1;
      end
      check("held_second_done_seen", seen, 1);
      check("held_second_iter", int'(act[0].iter), 2);
      @(negedge clk);

      st[0] = 1'b1;
      fd[0] = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         st[0] = 1'b0;
      end
      check("abort_in_add", int'(act[0].adw), 1);
      check("abort_add_iter", int'(act[0].iter), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_outputs_clear", int'(act[0]), 0);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (act[0].done) seen++;
      end
      check("abort_no_done", seen, 0);
      go(0, 2, 0, 0, off, mw, feeds);
      check("after_abort_done_cycle", off, 10);
      check("after_abort_iter", int'(act[0].iter), 2);

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst   = ($urandom_range(0, 299) == 0);
         st[0] = ($urandom_range(0, 7) == 0);
         st[1] = ($urandom_range(0, 7) == 0);
         fd[0] = ($urandom_range(0, 3) == 0);
         fd[1] = ($urandom_range(0, 4) == 0);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
